// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the playfield sequencing logic and the row array.
//   ROWS_DEFAULT  : default number of row registers (index 0 = top row)
//   board_code_e  : 3-bit board state code broadcast to every row register
//   ctrl_state_e  : internal states of the line-clear sequencing FSM
//   board_code()  : maps an FSM state onto the code the rows understand
// ---------------------------------------------------------------------------
package tetris_pkg;

  localparam int ROWS_DEFAULT = 20;

  typedef enum logic [2:0] {
    BOARD_CHECK = 3'b000,
    BOARD_MOVE  = 3'b001,
    BOARD_WRITE = 3'b010,
    BOARD_SHIFT = 3'b011,
    BOARD_ADD   = 3'b100
  } board_code_e;

  typedef enum logic [2:0] {
    ST_MOVE,
    ST_WRITE,
    ST_CHECK,
    ST_EVAL,
    ST_SHIFT,
    ST_ADD,
    ST_OVER
  } ctrl_state_e;

  // EVAL and OVER both present "hold" to the rows: nothing in the array may
  // change while the controller is deciding, or once the game has halted.
  function automatic board_code_e board_code(input ctrl_state_e s);
    board_code_e code;
    case (s)
      ST_WRITE: code = BOARD_WRITE;
      ST_CHECK: code = BOARD_CHECK;
      ST_SHIFT: code = BOARD_SHIFT;
      ST_ADD:   code = BOARD_ADD;
      default:  code = BOARD_MOVE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/full_row_finder.sv
// ---------------------------------------------------------------------------
// full_row_finder
// Combinational helper for the line-clear controller.
//   row_full  in  ROWS   per-row full flags from the row array
//   k_sel     in  IDX_W  latched bottom-most full row index
//   any_full  out 1      at least one row is full
//   hi_idx    out IDX_W  highest set index of row_full (bottom-most full row)
//   mask      out ROWS   thermometer mask with bits 0..k_sel set
// ---------------------------------------------------------------------------
module full_row_finder #(
  parameter int ROWS  = 20,
  parameter int IDX_W = 5
) (
  input  logic [ROWS-1:0]  row_full,
  input  logic [IDX_W-1:0] k_sel,
  output logic             any_full,
  output logic [IDX_W-1:0] hi_idx,
  output logic [ROWS-1:0]  mask
);

  // Ascending scan so the last hit wins, leaving the bottom-most full row.
  always_comb begin
    any_full = |row_full;
    hi_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_full[i]) hi_idx = IDX_W'(i);
    end
  end

  // Every row at or above the cleared one moves down by one, so the shift
  // enable is a thermometer from the top row down to k.
  always_comb begin
    mask = '0;
    for (int i = 0; i < ROWS; i++) begin
      mask[i] = (IDX_W'(i) <= k_sel);
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// ---------------------------------------------------------------------------
// line_clear_ctrl
// Sequencing controller for the playfield row array. After a piece locks it
// walks the rows through write, check, shift (once per full row, bottom
// first) and add, then returns to move or halts on a blocked spawn.
//   clk            in   1        system clock
//   reset_n        in   1        asynchronous active-low reset
//   lock           in   1        piece has landed (honoured only in MOVE)
//   spawn_blocked  in   1        new piece overlaps occupied cells
//   row_full       in   ROWS     per-row full flags, valid during EVAL
//   state          out  3        board state code broadcast to the rows
//   shift_row      out  ROWS     per-row shift enable (with code 011)
//   busy           out  1        sequencing in progress
//   spawn          out  1        new piece is being added this cycle
//   lines_cleared  out  3        rows cleared by the last lock, saturating
//   lines_total    out  TOTAL_W  running cleared-row total, saturating
//   game_over      out  1        sticky halt flag
// ---------------------------------------------------------------------------
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS    = ROWS_DEFAULT,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lock,
  input  logic               spawn_blocked,
  input  logic [ROWS-1:0]    row_full,
  output logic [2:0]         state,
  output logic [ROWS-1:0]    shift_row,
  output logic               busy,
  output logic               spawn,
  output logic [2:0]         lines_cleared,
  output logic [TOTAL_W-1:0] lines_total,
  output logic               game_over
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  ctrl_state_e        state_q, state_d;
  logic [IDX_W-1:0]   k_q;
  logic [2:0]         cleared_q;
  logic [TOTAL_W-1:0] total_q;
  logic               any_full;
  logic [IDX_W-1:0]   hi_idx;
  logic [ROWS-1:0]    shift_mask;

  full_row_finder #(
    .ROWS  (ROWS),
    .IDX_W (IDX_W)
  ) u_finder (
    .row_full (row_full),
    .k_sel    (k_q),
    .any_full (any_full),
    .hi_idx   (hi_idx),
    .mask     (shift_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_MOVE;
    else          state_q <= state_d;
  end

  // Each SHIFT loops back to CHECK so the rows re-evaluate after every
  // single-row clear; the loop ends when EVAL sees no full row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MOVE:  if (lock) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_CHECK;
      ST_CHECK: state_d = ST_EVAL;
      ST_EVAL:  state_d = any_full ? ST_SHIFT : ST_ADD;
      ST_SHIFT: state_d = ST_CHECK;
      ST_ADD:   state_d = spawn_blocked ? ST_OVER : ST_MOVE;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_MOVE;
    endcase
  end

  // Bottom-most full row, captured while the row flags are valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          k_q <= '0;
    else if (state_q == ST_EVAL && any_full) k_q <= hi_idx;
  end

  // The per-lock count restarts on an accepted lock; both counters bump
  // once per SHIFT and stick at their maximum rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cleared_q <= '0;
      total_q   <= '0;
    end else if (state_q == ST_MOVE && lock) begin
      cleared_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      if (cleared_q != 3'd7) cleared_q <= cleared_q + 3'd1;
      if (total_q != '1)     total_q   <= total_q + TOTAL_W'(1);
    end
  end

  always_comb begin
    state         = board_code(state_q);
    shift_row     = (state_q == ST_SHIFT) ? shift_mask : '0;
    busy          = (state_q != ST_MOVE) && (state_q != ST_OVER);
    spawn         = (state_q == ST_ADD);
    game_over     = (state_q == ST_OVER);
    lines_cleared = cleared_q;
    lines_total   = total_q;
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_clear_ctrl
// Self-checking bench for line_clear_ctrl (ROWS=20, TOTAL_W=16).
// ---------------------------------------------------------------------------
module tb_line_clear_ctrl;

  logic        clk;
  logic        reset_n;
  logic        lock;
  logic        spawn_blocked;
  logic [19:0] row_full;
  logic [2:0]  state;
  logic [19:0] shift_row;
  logic        busy;
  logic        spawn;
  logic [2:0]  lines_cleared;
  logic [15:0] lines_total;
  logic        game_over;

  line_clear_ctrl #(
    .ROWS    (20),
    .TOTAL_W (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lock          (lock),
    .spawn_blocked (spawn_blocked),
    .row_full      (row_full),
    .state         (state),
    .shift_row     (shift_row),
    .busy          (busy),
    .spawn         (spawn),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .game_over     (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One expected cycle of the board: outputs plus the inputs to drive.
  typedef struct packed {
    logic [2:0]  st;
    logic [19:0] sh;
    logic        sp;
    logic        bz;
    logic        go;
    logic [2:0]  lc;
    logic [15:0] lt;
    logic [19:0] rf;
    logic        lk;
  } ent_t;

  ent_t        tr[$];
  ent_t        ex;
  ent_t        restE;
  logic [19:0] pass [0:31];
  logic [2:0]  mLc;
  logic [15:0] mLt;
  logic        mGo;
  logic        chk;
  int          nCompared;
  int          nMismatched;

  function automatic ent_t mk(input logic [2:0] st, input logic [19:0] sh,
                              input logic sp, input logic bz,
                              input logic [19:0] rf, input logic lk);
    ent_t e;
    e.st = st; e.sh = sh; e.sp = sp; e.bz = bz; e.go = mGo;
    e.lc = mLc; e.lt = mLt; e.rf = rf; e.lk = lk;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Expected board trace for one accepted lock, built from the rules:
  // WRITE, CHECK, then per pass EVAL (+ SHIFT, CHECK while a row is full),
  // then ADD and finally MOVE or OVER.
  task automatic buildTrace(input int np, input bit blocked,
                            input bit lockInShift, input bit lockAtAdd);
    logic [19:0] f;
    logic [19:0] m;
    int          hi;
    tr.delete();
    mLc = 3'd0;
    tr.push_back(mk(3'b010, 20'h0, 1'b0, 1'b1, 20'h0, 1'b0));
    tr.push_back(mk(3'b000, 20'h0, 1'b0, 1'b1, 20'h0, 1'b0));
    for (int p = 0; p < np; p++) begin
      f = pass[p];
      tr.push_back(mk(3'b001, 20'h0, 1'b0, 1'b1, f, 1'b0));
      if (f == 20'h0) break;
      hi = 0;
      for (int j = 0; j < 20; j++) if (f[j]) hi = j;
      m = 20'h0;
      for (int j = 0; j <= hi; j++) m[j] = 1'b1;
      tr.push_back(mk(3'b011, m, 1'b0, 1'b1, 20'h0, lockInShift));
      if (mLc < 3'd7) mLc = mLc + 3'd1;
      if (mLt < 16'hFFFF) mLt = mLt + 16'd1;
      tr.push_back(mk(3'b000, 20'h0, 1'b0, 1'b1, 20'h0, 1'b0));
    end
    tr.push_back(mk(3'b100, 20'h0, 1'b1, 1'b1, 20'h0, lockAtAdd));
    if (blocked) mGo = 1'b1;
    restE = mk(3'b001, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses lock, then plays the expected trace one cycle at a time.
  // stopAt >= 0 returns while that trace cycle is in progress.
  task automatic applyStimulus(input int np, input bit blocked,
                               input bit lockInShift, input bit lockAtAdd,
                               input int stopAt);
    buildTrace(np, blocked, lockInShift, lockAtAdd);
    spawn_blocked = blocked;
    lock = 1'b1;
    idle(1);
    lock = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      ex       = tr[i];
      row_full = tr[i].rf;
      lock     = tr[i].lk;
      if (i == stopAt) return;
      idle(1);
    end
    ex       = restE;
    row_full = 20'h0;
    lock     = 1'b0;
  endtask

  task automatic modelReset();
    mLc = 3'd0;
    mLt = 16'd0;
    mGo = 1'b0;
    ex  = mk(3'b001, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk) begin
      checkOutput("state", 32'(state), 32'(ex.st));
      if (ex.st == 3'b011) checkOutput("shift_row", 32'(shift_row), 32'(ex.sh));
      checkOutput("busy", 32'(busy), 32'(ex.bz));
      checkOutput("spawn", 32'(spawn), 32'(ex.sp));
      checkOutput("lines_cleared", 32'(lines_cleared), 32'(ex.lc));
      checkOutput("lines_total", 32'(lines_total), 32'(ex.lt));
      checkOutput("game_over", 32'(game_over), 32'(ex.go));
    end
  end

  logic [19:0] allRows;

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    chk           = 1'b0;
    lock          = 1'b0;
    spawn_blocked = 1'b0;
    row_full      = 20'h0;
    reset_n       = 1'b0;
    modelReset();
    restE = ex;
    idle(2);
    checkOutput("reset_shift_row", 32'(shift_row), 32'h0);
    reset_n = 1'b1;
    chk     = 1'b1;

    // Idle after reset: hold 10 cycles
    idle(10);
    checkOutput("idle_state_lit", 32'(state), 32'h1);
    checkOutput("idle_total_lit", 32'(lines_total), 32'h0);

    // No full rows
    pass[0] = 20'h0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    checkOutput("t2_cleared_lit", 32'(lines_cleared), 32'h0);

    // Bottom row full once
    pass[0] = 20'h80000;
    pass[1] = 20'h0;
    applyStimulus(2, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    checkOutput("t3_cleared_lit", 32'(lines_cleared), 32'h1);
    checkOutput("t3_total_lit", 32'(lines_total), 32'h1);

    // Rows 19 and 12 full; row 12 reappears at 13 after the first shift
    pass[0] = 20'h81000;
    pass[1] = 20'h02000;
    pass[2] = 20'h0;
    applyStimulus(3, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    checkOutput("t4_cleared_lit", 32'(lines_cleared), 32'h2);
    checkOutput("t4_total_lit", 32'(lines_total), 32'h3);

    // Locks during SHIFT and on the ADD->MOVE edge are ignored
    pass[0] = 20'h00020;
    pass[1] = 20'h0;
    applyStimulus(2, 1'b0, 1'b1, 1'b1, -1);
    idle(4);
    checkOutput("t5_total_lit", 32'(lines_total), 32'h4);

    // Whole board full: one row per pass, 20 passes, count saturates at 7
    allRows = 20'hFFFFF;
    for (int p = 0; p < 20; p++) pass[p] = allRows << p;
    pass[20] = 20'h0;
    applyStimulus(21, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    checkOutput("sat_cleared_lit", 32'(lines_cleared), 32'h7);
    checkOutput("sat_total_lit", 32'(lines_total), 32'd24);

    // Blocked spawn -> sticky game over; further locks ignored
    pass[0] = 20'h0;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, -1);
    spawn_blocked = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      lock = 1'b1;
      idle(1);
      lock = 1'b0;
      idle(1);
    end
    checkOutput("over_flag_lit", 32'(game_over), 32'h1);
    checkOutput("over_state_lit", 32'(state), 32'h1);

    // Reset clears the halt
    reset_n = 1'b0;
    modelReset();
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Reset asserted in the middle of SHIFT
    pass[0] = 20'h80000;
    pass[1] = 20'h0;
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 3);
    #1;
    reset_n  = 1'b0;
    row_full = 20'h0;
    lock     = 1'b0;
    modelReset();
    idle(2);
    reset_n = 1'b1;
    idle(3);
    checkOutput("midrst_total_lit", 32'(lines_total), 32'h0);
    checkOutput("midrst_busy_lit", 32'(busy), 32'h0);

    // Normal operation resumes
    pass[0] = 20'h0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, -1);
    idle(3);

    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
